// File: rtl/button_conditioner.sv
// Four-button conditioner: 2-flop synchronizer, tick-qualified debounce, press/release pulses.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_TICKS      = 4,
  parameter int REPEAT_DELAY_TICKS  = 50,
  parameter int REPEAT_PERIOD_TICKS = 10
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] key_n_i,
  input  logic       tick_i,
  output logic [3:0] btn_level_o,
  output logic [3:0] btn_press_o,
  output logic [3:0] btn_release_o
);

  localparam int        N        = 4;
  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_TICKS);

  logic [N-1:0] sync1_q, sync2_q;
  logic [N-1:0] level_q, level_d;
  logic [N-1:0] press_q, press_d;
  logic [N-1:0] release_q, release_d;
  logic [7:0]   db_cnt_q [N];
  logic [7:0]   db_cnt_d [N];

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [7:0] RPT_DELAY  = 8'(REPEAT_DELAY_TICKS);
  // After a repeat fires, reloading here makes the next hit exactly one period later.
  localparam logic [7:0] RPT_RELOAD = 8'(REPEAT_DELAY_TICKS - REPEAT_PERIOD_TICKS);
  logic [7:0] rpt_cnt_q [N];
  logic [7:0] rpt_cnt_d [N];
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY_TICKS + REPEAT_PERIOD_TICKS;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (tick_i) begin
        if (sync2_q[i] != level_q[i]) begin
          if (db_cnt_q[i] + 8'd1 == DB_LIMIT) begin
            level_d[i]   = ~level_q[i];
            press_d[i]   = ~level_q[i];
            release_d[i] = level_q[i];
            db_cnt_d[i]  = '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 8'd1;
          end
        end else begin
          db_cnt_d[i] = '0;
        end
      end
`ifdef BUTTON_AUTOREPEAT_EN
      // Held ticks count only between the press edge and the release edge, so a
      // repeat can never coincide with the falling edge.
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (!level_q[i] || !level_d[i]) begin
        rpt_cnt_d[i] = '0;
      end else if (tick_i) begin
        if (rpt_cnt_q[i] + 8'd1 == RPT_DELAY) begin
          press_d[i]   = 1'b1;
          rpt_cnt_d[i] = RPT_RELOAD;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 8'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      // NOTE: the counter arrays are small flop banks, not RAM, so they are reset too.
      for (int i = 0; i < N; i++) begin
        db_cnt_q[i] <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
        rpt_cnt_q[i] <= '0;
`endif
      end
    end else begin
      // NOTE: non-blocking assignments keep the two synchronizer stages distinct flops.
      sync1_q   <= ~key_n_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
`ifdef BUTTON_AUTOREPEAT_EN
        rpt_cnt_q[i] <= rpt_cnt_d[i];
`endif
      end
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: per-edge expected outputs are queued with
// each stimulus phase and popped as the DUT produces them.
module tb_button_conditioner;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic [3:0] key_n_i;
  logic       tick_i;
  logic [3:0] btn_level_o;
  logic [3:0] btn_press_o;
  logic [3:0] btn_release_o;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    press0_count = 0;
  string phase = "init";

  button_conditioner dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .key_n_i       (key_n_i),
    .tick_i        (tick_i),
    .btn_level_o   (btn_level_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int n, input logic [3:0] lvl, input logic [3:0] prs,
                          input logic [3:0] rel);
    exp_t e;
    e.level = lvl;
    e.press = prs;
    e.rel   = rel;
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  // Tick is high every edge when tick_div is 1, else on edges where e % tick_div == 0.
  task automatic run_edges(input int n, input int tick_div);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      tick_i = (tick_div == 1) ? 1'b1 : ((k % tick_div) == 0);
      @(posedge clock_i);
      #1;
      if (btn_press_o[0] === 1'b1) press0_count++;
      if (exp_q.size() == 0) begin
        check($sformatf("%s/e%0d/sb_empty", phase, k), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s/e%0d/level",   phase, k), {28'd0, btn_level_o},   {28'd0, e.level});
        check($sformatf("%s/e%0d/press",   phase, k), {28'd0, btn_press_o},   {28'd0, e.press});
        check($sformatf("%s/e%0d/release", phase, k), {28'd0, btn_release_o}, {28'd0, e.rel});
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    key_n_i = 4'hF;
    tick_i  = 1'b1;

    phase = "reset";
    push_exp(3, 4'h0, 4'h0, 4'h0);
    run_edges(3, 1);
    reset_i = 1'b0;
    phase = "idle";
    push_exp(4, 4'h0, 4'h0, 4'h0);
    run_edges(4, 1);

    // Single press on bit 3: level and press on the 6th edge, release symmetric.
    phase = "press3";
    key_n_i = 4'b0111;
    push_exp(5, 4'h0, 4'h0, 4'h0);
    push_exp(1, 4'h8, 4'h8, 4'h0);
    push_exp(4, 4'h8, 4'h0, 4'h0);
    run_edges(10, 1);
    phase = "release3";
    key_n_i = 4'hF;
    push_exp(5, 4'h8, 4'h0, 4'h0);
    push_exp(1, 4'h0, 4'h0, 4'h8);
    push_exp(3, 4'h0, 4'h0, 4'h0);
    run_edges(9, 1);

    // Bounce train on bit 2: 3 low / 1 high never reaches 4 consecutive samples.
    phase = "bounce2";
    for (int c = 0; c < 40; c++) begin
      key_n_i = ((c % 4) < 3) ? 4'b1011 : 4'b1111;
      push_exp(1, 4'h0, 4'h0, 4'h0);
      run_edges(1, 1);
    end
    key_n_i = 4'hF;
    push_exp(6, 4'h0, 4'h0, 4'h0);
    run_edges(6, 1);

    // Independent buttons: simultaneous press, then crossed press/release.
    phase = "multi_a";
    key_n_i = 4'b0110;
    push_exp(5, 4'h0, 4'h0, 4'h0);
    push_exp(1, 4'h9, 4'h9, 4'h0);
    push_exp(2, 4'h9, 4'h0, 4'h0);
    run_edges(8, 1);
    phase = "multi_b";
    key_n_i = 4'b1011;
    push_exp(5, 4'h9, 4'h0, 4'h0);
    push_exp(1, 4'h4, 4'h4, 4'h9);
    push_exp(2, 4'h4, 4'h0, 4'h0);
    run_edges(8, 1);
    phase = "multi_c";
    key_n_i = 4'hF;
    push_exp(5, 4'h4, 4'h0, 4'h0);
    push_exp(1, 4'h0, 4'h0, 4'h4);
    push_exp(2, 4'h0, 4'h0, 4'h0);
    run_edges(8, 1);

    // Long hold on bit 0: repeats at held ticks 50,60,...,100 only with auto-repeat.
    phase = "hold0";
    press0_count = 0;
    key_n_i = 4'b1110;
    push_exp(5, 4'h0, 4'h0, 4'h0);
    push_exp(1, 4'h1, 4'h1, 4'h0);
    for (int k = 1; k <= 100; k++) begin
      push_exp(1, 4'h1, (RPT_EN && k >= 50 && ((k - 50) % 10) == 0) ? 4'h1 : 4'h0, 4'h0);
    end
    run_edges(106, 1);
    phase = "unhold0";
    key_n_i = 4'hF;
    push_exp(5, 4'h1, 4'h0, 4'h0);
    push_exp(1, 4'h0, 4'h0, 4'h1);
    push_exp(2, 4'h0, 4'h0, 4'h0);
    run_edges(8, 1);
    check("hold0/press_count", press0_count, RPT_EN ? 32'd7 : 32'd1);

    // Reset while bit 1 is held: no release, then a fresh press after re-debounce.
    phase = "held1";
    key_n_i = 4'b1101;
    push_exp(5, 4'h0, 4'h0, 4'h0);
    push_exp(1, 4'h2, 4'h2, 4'h0);
    push_exp(3, 4'h2, 4'h0, 4'h0);
    run_edges(9, 1);
    phase = "reset_held1";
    reset_i = 1'b1;
    push_exp(1, 4'h0, 4'h0, 4'h0);
    run_edges(1, 1);
    reset_i = 1'b0;
    phase = "after_reset1";
    push_exp(5, 4'h0, 4'h0, 4'h0);
    push_exp(1, 4'h2, 4'h2, 4'h0);
    push_exp(2, 4'h2, 4'h0, 4'h0);
    run_edges(8, 1);
    phase = "release1";
    key_n_i = 4'hF;
    push_exp(5, 4'h2, 4'h0, 4'h0);
    push_exp(1, 4'h0, 4'h0, 4'h2);
    push_exp(2, 4'h0, 4'h0, 4'h0);
    run_edges(8, 1);

    // Sparse tick (every 4th edge): qualified samples at edges 4,8,12,16.
    phase = "tick4_press1";
    key_n_i = 4'b1101;
    push_exp(15, 4'h0, 4'h0, 4'h0);
    push_exp(1,  4'h2, 4'h2, 4'h0);
    push_exp(4,  4'h2, 4'h0, 4'h0);
    run_edges(20, 4);
    phase = "tick4_release1";
    key_n_i = 4'hF;
    push_exp(15, 4'h2, 4'h0, 4'h0);
    push_exp(1,  4'h0, 4'h0, 4'h2);
    push_exp(4,  4'h0, 4'h0, 4'h0);
    run_edges(20, 4);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
